// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code parser tracking W/S/O/L make/break state.
// Optional stuck-key idle timeout: define STUCK_KEY_TIMEOUT_EN.
module ps2_key_tracker #(
`ifdef STUCK_KEY_TIMEOUT_EN
    parameter logic [25:0] TIMEOUT_CYCLES = 26'd50000000,
`endif
    parameter logic [7:0] KEY_W = 8'h1D,
    parameter logic [7:0] KEY_S = 8'h1B,
    parameter logic [7:0] KEY_O = 8'h44,
    parameter logic [7:0] KEY_L = 8'h4B
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] key_data,
    input  logic       key_pressed,
    output logic [3:0] key_held,
    output logic [3:0] press_pulse,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic [1:0] parse_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       kp_q;
    logic [3:0] held_q, held_d;
    logic [3:0] pulse_q;
    logic [3:0] pad_q, pad_d;
    logic       accept;
    logic [3:0] hit;

    assign accept = key_pressed & ~kp_q;

    // One-hot {L,O,S,W} match of the current byte against the game keys
    assign hit = {key_data == KEY_L, key_data == KEY_O,
                  key_data == KEY_S, key_data == KEY_W};

`ifdef STUCK_KEY_TIMEOUT_EN
    logic [25:0] idle_q;
    logic        expired;

    assign expired = ~accept & (idle_q == TIMEOUT_CYCLES);

    // Idle counter: cleared by any accepted byte, saturates at the timeout
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idle_q <= '0;
        end else if (accept) begin
            idle_q <= '0;
        end else if (idle_q != TIMEOUT_CYCLES) begin
            idle_q <= idle_q + 26'd1;
        end
    end
`else
    logic expired;
    assign expired = 1'b0;
`endif

    // Parser next state and held-key update on accepted bytes
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (key_data == 8'hF0) begin
                        state_d = BRK;
                    end else if (key_data == 8'hE0 || key_data == 8'hE1) begin
                        state_d = EXT;
                    end else if (key_data == 8'hAA || key_data == 8'h00 ||
                                 key_data == 8'hFF) begin
                        held_d = '0;
                    end else if (key_data != 8'hFA && key_data != 8'hFE) begin
                        held_d = held_q | hit;
                    end
                end
                BRK: begin
                    if (key_data == 8'hE0) begin
                        state_d = EXT_BRK;
                    end else if (key_data != 8'hF0) begin
                        held_d  = held_q & ~hit;
                        state_d = IDLE;
                    end
                end
                EXT: begin
                    state_d = (key_data == 8'hF0) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        if (expired) begin
            held_d = '0;
        end
    end

    // Paddle commands: opposing keys cancel out
    always_comb begin
        pad_d = {held_d[0] & ~held_d[1], held_d[1] & ~held_d[0],
                 held_d[2] & ~held_d[3], held_d[3] & ~held_d[2]};
    end

    // Registered parser state, strobe history and outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            kp_q    <= 1'b0;
            held_q  <= '0;
            pulse_q <= '0;
            pad_q   <= '0;
        end else begin
            state_q <= state_d;
            kp_q    <= key_pressed;
            held_q  <= held_d;
            pulse_q <= held_d & ~held_q;
            pad_q   <= pad_d;
        end
    end

    assign key_held    = held_q;
    assign press_pulse = pulse_q;
    assign p1_up       = pad_q[3];
    assign p1_down     = pad_q[2];
    assign p2_up       = pad_q[1];
    assign p2_down     = pad_q[0];
    assign parse_state = state_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker.
// Define STUCK_KEY_TIMEOUT_EN to also exercise the idle timeout.
module tb_ps2_key_tracker;

    typedef struct packed {
        logic [3:0] held;
        logic [3:0] pulse;
        logic [3:0] pad;
        logic [1:0] st;
    } exp_t;

    logic       clock;
    logic       resetn;
    logic [7:0] key_data;
    logic       key_pressed;
    logic [3:0] key_held;
    logic [3:0] press_pulse;
    logic       p1_up, p1_down, p2_up, p2_down;
    logic [1:0] parse_state;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    ps2_key_tracker #(
`ifdef STUCK_KEY_TIMEOUT_EN
        .TIMEOUT_CYCLES(26'd100),
`endif
        .KEY_W(8'h1D)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .key_data(key_data),
        .key_pressed(key_pressed),
        .key_held(key_held),
        .press_pulse(press_pulse),
        .p1_up(p1_up),
        .p1_down(p1_down),
        .p2_up(p2_up),
        .p2_down(p2_down),
        .parse_state(parse_state)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic exp_t obs();
        return {key_held, press_pulse,
                {p1_up, p1_down, p2_up, p2_down}, parse_state};
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        key_pressed = 1'b0;
        key_data = 8'h00;
        sb.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    // One-cycle strobe; returns on the negedge after acceptance
    task automatic drive(input logic [7:0] b, input exp_t e);
        @(negedge clock);
        key_data = b;
        key_pressed = 1'b1;
        sb.push_back(e);
        @(negedge clock);
        key_pressed = 1'b0;
    endtask

    task automatic test_reset();
        exp_t o;
        do_reset();
        o = obs();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset got=%h want=0", o);
        end
    endtask

    task automatic test_make_repeat();
        exp_t e, o;
        do_reset();
        drive(8'h1D, '{4'b0001, 4'b0001, 4'b1000, 2'd0});
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin
            errors++; $display("FAIL make got=%h want=%h", o, e);
        end
        @(negedge clock);
        checks++;
        if (press_pulse !== 4'b0000) begin
            errors++; $display("FAIL pulse_width got=%b want=0000", press_pulse);
        end
        drive(8'h1D, '{4'b0001, 4'b0000, 4'b1000, 2'd0});
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin
            errors++; $display("FAIL typematic got=%h want=%h", o, e);
        end
    endtask

    task automatic test_break();
        logic [7:0] b[4] = '{8'h1D, 8'h44, 8'hF0, 8'h1D};
        exp_t x[4] = '{'{4'b0001, 4'b0001, 4'b1000, 2'd0},
                       '{4'b0101, 4'b0100, 4'b1010, 2'd0},
                       '{4'b0101, 4'b0000, 4'b1010, 2'd1},
                       '{4'b0100, 4'b0000, 4'b0010, 2'd0}};
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(b[i], x[i]);
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL break[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_conflict();
        logic [7:0] b[4] = '{8'h1D, 8'h1B, 8'hF0, 8'h1D};
        exp_t x[4] = '{'{4'b0001, 4'b0001, 4'b1000, 2'd0},
                       '{4'b0011, 4'b0010, 4'b0000, 2'd0},
                       '{4'b0011, 4'b0000, 4'b0000, 2'd1},
                       '{4'b0010, 4'b0000, 4'b0100, 2'd0}};
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(b[i], x[i]);
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL conflict[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_extended();
        logic [7:0] b[7] = '{8'hE0, 8'h1D, 8'hE0, 8'hF0, 8'h1B,
                             8'hE1, 8'h44};
        logic [1:0] s[7] = '{2'd2, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(b[i], '{4'b0, 4'b0, 4'b0, s[i]});
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL ext[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_bat();
        logic [7:0] b[4] = '{8'h1D, 8'h4B, 8'hFA, 8'hAA};
        exp_t x[4] = '{'{4'b0001, 4'b0001, 4'b1000, 2'd0},
                       '{4'b1001, 4'b1000, 4'b1001, 2'd0},
                       '{4'b1001, 4'b0000, 4'b1001, 2'd0},
                       '{4'b0000, 4'b0000, 4'b0000, 2'd0}};
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(b[i], x[i]);
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL bat[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_long_strobe_reset();
        int np;
        exp_t e, o;
        do_reset();
        @(negedge clock);
        key_data = 8'h4B;
        key_pressed = 1'b1;
        np = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            np += int'(press_pulse[3]);
        end
        key_pressed = 1'b0;
        @(negedge clock);
        np += int'(press_pulse[3]);
        checks++;
        if (np != 1 || key_held !== 4'b1000) begin
            errors++;
            $display("FAIL long_strobe got=%0d/%b want=1/1000", np, key_held);
        end
        drive(8'hF0, '{4'b1000, 4'b0000, 4'b0001, 2'd1});
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin
            errors++; $display("FAIL pre_reset got=%h want=%h", o, e);
        end
        #3 resetn = 1'b0;
        #1;
        o = obs(); checks++;
        if (o !== '0) begin
            errors++; $display("FAIL mid_reset got=%h want=0", o);
        end
        @(negedge clock);
        resetn = 1'b1;
        drive(8'h4B, '{4'b1000, 4'b1000, 4'b0001, 2'd0});
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin
            errors++; $display("FAIL post_reset got=%h want=%h", o, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[4] = '{8'h1D, 8'h44, 8'h4B, 8'h1B};
        exp_t x[4] = '{'{4'b0001, 4'b0001, 4'b1000, 2'd0},
                       '{4'b0101, 4'b0100, 4'b1010, 2'd0},
                       '{4'b1101, 4'b1000, 4'b1000, 2'd0},
                       '{4'b1111, 4'b0010, 4'b0000, 2'd0}};
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(b[i], x[i]);
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL b2b[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

`ifdef STUCK_KEY_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e, o;
        do_reset();
        drive(8'h1D, '{4'b0001, 4'b0001, 4'b1000, 2'd0});
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin
            errors++; $display("FAIL to_make got=%h want=%h", o, e);
        end
        repeat (110) @(negedge clock);
        checks++;
        if (key_held !== 4'b0000 || p1_up !== 1'b0) begin
            errors++; $display("FAIL to_clear got=%b want=0000", key_held);
        end
        drive(8'h1D, '{4'b0001, 4'b0001, 4'b1000, 2'd0});
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin
            errors++; $display("FAIL to_remake got=%h want=%h", o, e);
        end
        for (int i = 0; i < 4; i++) begin
            repeat (48) @(negedge clock);
            drive(8'h1D, '{4'b0001, 4'b0000, 4'b1000, 2'd0});
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL to_keep[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_make_repeat();
        test_break();
        test_conflict();
        test_extended();
        test_bat();
        test_long_strobe_reset();
        test_back_to_back();
`ifdef STUCK_KEY_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sits between the PS/2 byte receiver and the VGA game controller.
- Consumes raw set-2 scan-code bytes and tracks make/break state for the four game keys: W, S, O, L.
- Outputs held levels that stay valid while a key is held, so both paddles can move at the same time.
- Also outputs per-paddle direction signals with conflict resolution, and one-cycle press pulses.

Parameters:
- KEY_W, 8'h1D, set-2 make code for player-1 up.
- KEY_S, 8'h1B, set-2 make code for player-1 down.
- KEY_O, 8'h44, set-2 make code for player-2 up.
- KEY_L, 8'h4B, set-2 make code for player-2 down.
- TIMEOUT_CYCLES, 50000000, idle cycles before stuck-key clear. Used only with STUCK_KEY_TIMEOUT_EN.

Ports:
- clock  input  1  system clock (50 MHz).
- resetn  input  1  asynchronous, active-low reset.
- key_data  input  8  received scan-code byte; valid only when qualified by key_pressed.
- key_pressed  input  1  byte strobe from the PS/2 receiver.
- key_held  output  4  {L,O,S,W} held levels.
- press_pulse  output  4  {L,O,S,W} one-cycle pulse on a new press.
- p1_up, p1_down, p2_up, p2_down  output  1 each  resolved paddle commands.
- parse_state  output  2  debug: current parser state encoding.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `resetn` is asynchronous and active-low.
- Reset values: all outputs 0; parser state IDLE (2'd0).
- Byte qualification:
  - A byte is accepted on the rising edge of key_pressed, using a registered previous value.
  - If key_pressed stays high for N cycles, exactly one byte is accepted.
  - key_data is sampled in the same cycle as the edge.
- Parser FSM (encodings IDLE=0, BRK=1, EXT=2, EXT_BRK=3), evaluated only on accepted bytes:
  - IDLE:
    - F0 -> BRK.
    - E0 -> EXT.
    - E1 -> EXT (pause-sequence bytes are discarded one at a time).
    - AA, 00, FF (BAT or error) -> clear all key_held, stay IDLE.
    - FA, FE -> ignored.
    - Any other byte is a make code: if it equals a KEY_* value, set that key_held bit; otherwise ignore. Stay IDLE.
  - BRK:
    - F0 -> stay BRK.
    - E0 -> EXT_BRK.
    - Any other byte: clear the matching key_held bit (no-op if not held or not matched), then -> IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - Any other byte is discarded (extended keys never alias game keys) -> IDLE.
  - EXT_BRK: any byte is discarded -> IDLE.
- Latency: key_held, press_pulse and p*_ outputs are registered and update 1 cycle after the accepted-byte cycle.
- press_pulse: high for exactly 1 cycle when a make sets a previously clear bit. Typematic repeats of an already-held key produce no pulse.
- Paddle resolution, registered from the next-state key_held, same latency:
  - p1_up = W & ~S; p1_down = S & ~W.
  - p2_up = O & ~L; p2_down = L & ~O.
  - Both keys held gives both outputs 0.
- Bursts: back-to-back accepted bytes at any spacing of at least 2 cycles must be processed correctly, with no byte lost.
- Reset mid-sequence (e.g. after F0): FSM returns to IDLE and held keys clear; the next byte is parsed as a fresh make/break.

Optional Feature:
- Macro: STUCK_KEY_TIMEOUT_EN.
- When defined:
  - A 26-bit idle counter resets to 0 on every accepted byte.
  - It increments otherwise, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES while any key_held is set, all key_held clear in that cycle (lost break codes cannot lock a paddle).
  - FSM state is unaffected.
  - Because the PS/2 typematic repeat (~100 ms) refreshes the counter, a genuinely held key survives.
- When undefined: no counter is present; held keys persist until a break code or reset.

Test Plan:
- Reset, then bytes 1D -> key_held=0001, press_pulse=0001 for 1 cycle, p1_up=1; then 1D again -> no pulse, key_held unchanged.
- Bytes 1D, 44, F0 1D -> after the third code key_held=0100, p1_up=0, p2_up=1.
- Bytes 1D, 1B -> key_held=0011, p1_up=p1_down=0; then F0 1D -> p1_down=1.
- Bytes E0 1D, then E0 F0 1B with W/S clear -> key_held stays 0000; parse_state returns to 0 after each sequence.
- key_pressed held high 5 cycles with 4B -> key_held=1000, exactly one pulse; then reset asserted mid F0 sequence -> outputs 0, parse_state=0, next byte 4B is treated as a make.
- With STUCK_KEY_TIMEOUT_EN and TIMEOUT_CYCLES=100: byte 1D, then no bytes for 100 cycles -> key_held=0000; repeat 1D every 50 cycles -> key_held stays 0001.
